freq_meter_array: RTL
=====================

FREQ_METER_ARRAY -- requirements
Module: freq_meter_array

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of measured channels, legal 1..8.
REQ-002 SHALL have parameter CNT_W, default 32: edge-counter and result width.
REQ-003 SHALL have parameter GATE_CYCLES, default 50000000: gate length in clk_clk cycles, legal 2..2^32-1.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal 2..4.
REQ-005 SHALL have port clk_clk, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port reset_reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1: measurement run.
REQ-008 SHALL have port sig_in, input, N_CH: asynchronous measured signals.
REQ-009 SHALL have port freq_data, output, CNT_W: result word.
REQ-010 SHALL have port freq_ch, output, CH_W = max(1,clog2(N_CH)): channel of freq_data.
REQ-011 SHALL have port freq_en, output, 1: result valid.
REQ-012 SHALL have port freq_ack, input, 1: consumer accept.
REQ-013 SHALL have port ovf, output, N_CH: per-channel overflow of the frame being drained.
REQ-014 SHALL have port overrun, output, 1: sticky; a frame was dropped.
REQ-015 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-016 SHALL synchronise each sig_in bit through SYNC_STAGES flops and count one edge per 0->1 transition between the last two stages.
REQ-017 SHALL use states IDLE, GATE: IDLE->GATE when enable=1; any state->IDLE in the cycle after enable=0.
REQ-018 SHALL, in GATE, run a gate timer 0..GATE_CYCLES-1; at terminal count, copy all counters (including edges detected that cycle) and overflow flags to a shadow frame, then restart counters and timer from 0 with no dead cycle.
REQ-019 SHALL drain the shadow frame independently of counting: freq_en rises the cycle after terminal count with freq_ch=0.
REQ-020 SHALL hold freq_data and freq_ch stable while freq_en=1 and freq_ack=0.
REQ-021 SHALL advance to the next channel the cycle after freq_en&freq_ack; after channel N_CH-1 is acked, freq_en=0 and the frame is released; back-to-back acks give one word per cycle.
REQ-022 SHALL, if terminal count occurs while a frame is still undrained, discard the new frame, keep draining the old frame, and set overrun.
REQ-023 SHALL hold overrun until reset or enable=0.
REQ-024 SHALL, on enable=0, clear counters, timer, shadow, ovf and overrun, and drop freq_en the next cycle, aborting any partial frame or drain.
REQ-025 SHALL set ovf[i] for a frame when channel i's counter exceeds 2^CNT_W-1 during that gate.

Reset
REQ-026 SHALL, on reset_reset_n=0, asynchronously set state=IDLE, freq_data=0, freq_ch=0, freq_en=0, ovf=0, overrun=0, busy=0, clear all counters, the timer and the synchroniser flops.
REQ-027 SHALL start operation on the first clock edge after reset_reset_n rises, counting no edge in that first cycle.

Configuration
REQ-028 SHALL support macro FREQ_SAT_EN: defined -> counters saturate at 2^CNT_W-1; undefined -> counters wrap modulo 2^CNT_W. ovf is set identically in both builds.

Structure
REQ-029 SHALL place the state enum, CH_W function and default parameter constants in package freq_meter_pkg.
REQ-030 SHALL implement one channel (synchroniser, edge detect, counter, ovf) as sub-module freq_ch_counter, instantiated N_CH times.

Verification
REQ-031 SHALL cover: N_CH=4, GATE_CYCLES=100, sig_in[k] period 10·(k+1) cycles, freq_ack tied 1 -> per gate, four consecutive freq_en words with ch 0..3 and data 10, 5, 3 or 4, 2 or 3.
REQ-032 SHALL cover: freq_ack held 0 for 20 cycles on ch 1 -> freq_data and freq_ch frozen, then ch 2 the cycle after ack.
REQ-033 SHALL cover: freq_ack=0 for more than 100 cycles -> second frame dropped, overrun=1, ch 0 data from the first frame preserved.
REQ-034 SHALL cover: CNT_W=4, 20 edges in a gate -> ovf[0]=1; data=4 without FREQ_SAT_EN, data=15 with it.
REQ-035 SHALL cover: enable dropped mid-drain at ch 2 -> freq_en=0 next cycle, busy=0, overrun=0; re-enable restarts the timer at 0.
REQ-036 SHALL cover: reset_reset_n asserted mid-gate with no clock edge -> all outputs 0 immediately.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency meter array.
// Gate FSM states, channel-index width helper and default parameter constants.
package freq_meter_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      GATE = 1'b1
   } state_t;

   localparam int          DEF_N_CH        = 4;
   localparam int          DEF_CNT_W       = 32;
   localparam logic [31:0] DEF_GATE_CYCLES = 32'd50000000;
   localparam int          DEF_SYNC_STAGES = 2;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/freq_ch_counter.sv
// One channel: input synchroniser, rising-edge detect, edge counter with overflow flag.
// snap_* is the count including this cycle's edge; FREQ_SAT_EN selects saturate instead of wrap.
module freq_ch_counter
   import freq_meter_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             clr,
   input  logic             run,
   input  logic             restart,
   input  logic             sig_in,
   output logic [CNT_W-1:0] snap_cnt,
   output logic             snap_ovf
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_q;
   logic                   edge_det;
   logic                   at_max;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      end
   end

   assign edge_det = run & sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
   assign at_max   = &cnt_q;

`ifdef FREQ_SAT_EN
   assign snap_cnt = cnt_q + CNT_W'(edge_det & ~at_max);
`else
   assign snap_cnt = cnt_q + CNT_W'(edge_det);
`endif
   // Overflow is flagged on the edge that would exceed full scale, in either build.
   assign snap_ovf = ovf_q | (edge_det & at_max);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clr || restart) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= snap_cnt;
         ovf_q <= snap_ovf;
      end
   end

endmodule

// File: rtl/freq_meter_array.sv
// Multi-channel gated frequency meter; one result word per channel per gate, drained over valid/ack.
// Result appears 1 cycle after gate end; a stalled drain holds the word and drops later frames (overrun).
module freq_meter_array
   import freq_meter_pkg::*;
#(
   parameter int          N_CH        = DEF_N_CH,
   parameter int          CNT_W       = DEF_CNT_W,
   parameter logic [31:0] GATE_CYCLES = DEF_GATE_CYCLES,
   parameter int          SYNC_STAGES = DEF_SYNC_STAGES,
   localparam int         CH_W        = ch_w(N_CH)
) (
   input  logic             clk_clk,
   input  logic             reset_reset_n,
   input  logic             enable,
   input  logic [N_CH-1:0]  sig_in,
   output logic [CNT_W-1:0] freq_data,
   output logic [CH_W-1:0]  freq_ch,
   output logic             freq_en,
   input  logic             freq_ack,
   output logic [N_CH-1:0]  ovf,
   output logic             overrun,
   output logic             busy
);

   localparam int              TMR_W    = $clog2(GATE_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 32'd1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

   state_t           state_q, state_d;
   logic [TMR_W-1:0] tmr_q;
   logic             gate_run;
   logic             tc;

   logic [CNT_W-1:0] snap_cnt [N_CH];
   logic [N_CH-1:0]  snap_ovf;

   logic [CNT_W-1:0] shadow_q [N_CH];
   logic [N_CH-1:0]  shadow_ovf_q;
   logic             frame_vld_q;
   logic [CH_W-1:0]  rd_ch_q;
   logic             overrun_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!enable) begin
         state_d = IDLE;
      end else if (state_q == IDLE) begin
         state_d = GATE;
      end
   end

   assign gate_run = (state_q == GATE) && enable;
   assign tc       = gate_run && (tmr_q == TMR_LAST);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         tmr_q <= '0;
      end else if (!gate_run || tc) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_q + TMR_W'(1);
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      freq_ch_counter #(
         .CNT_W       (CNT_W),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_cnt (
         .clk_clk       (clk_clk),
         .reset_reset_n (reset_reset_n),
         .clr           (~enable),
         .run           (gate_run),
         .restart       (tc),
         .sig_in        (sig_in[i]),
         .snap_cnt      (snap_cnt[i]),
         .snap_ovf      (snap_ovf[i])
      );
   end

   // Drain and capture share one block; a capture is only taken when no frame is pending,
   // so the two never update the read pointer in the same cycle.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
         shadow_ovf_q <= '0;
         frame_vld_q  <= 1'b0;
         rd_ch_q      <= '0;
         overrun_q    <= 1'b0;
      end else if (!enable) begin
         for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
         shadow_ovf_q <= '0;
         frame_vld_q  <= 1'b0;
         rd_ch_q      <= '0;
         overrun_q    <= 1'b0;
      end else begin
         if (frame_vld_q && freq_ack) begin
            if (rd_ch_q == CH_LAST) begin
               frame_vld_q <= 1'b0;
               rd_ch_q     <= '0;
            end else begin
               rd_ch_q <= rd_ch_q + CH_W'(1);
            end
         end
         if (tc) begin
            if (frame_vld_q) begin
               overrun_q <= 1'b1;
            end else begin
               for (int i = 0; i < N_CH; i++) shadow_q[i] <= snap_cnt[i];
               shadow_ovf_q <= snap_ovf;
               frame_vld_q  <= 1'b1;
               rd_ch_q      <= '0;
            end
         end
      end
   end

   assign freq_data = shadow_q[rd_ch_q];
   assign freq_ch   = rd_ch_q;
   assign freq_en   = frame_vld_q;
   assign ovf       = shadow_ovf_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q == GATE);

endmodule
